ram_fifo_reader: RTL
====================

RAM_FIFO_READER -- requirements
Module: ram_fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning the width of the RAM read port and the output stream.
REQ-002 SHALL have parameter RD_LATENCY, default 1, meaning the cycles from ren asserted to rdata valid (legal values 1..2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset; the ports are clk and rst_n.
REQ-004 clk  input  1  sole clock; the RAM FIFO read clock (RCLK) SHALL be driven from the same net.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 fifo_empty  input  1  FIFO empty flag (FFLAGS empty bit), synchronous to clk.
REQ-007 flush  input  1  single-cycle request to discard buffered and in-flight data.
REQ-008 rdata  input  DATA_WIDTH  RAM RDATA.
REQ-009 ren  output  1  RAM REN.
REQ-010 fflush  output  1  RAM FFLUSH.
REQ-011 m_data  output  DATA_WIDTH  stream data.
REQ-012 m_valid  output  1  stream valid.
REQ-013 m_ready  input  1  stream ready.
REQ-014 rd_count  output  16  count of words delivered (m_valid and m_ready both high), wrapping.

Function
REQ-015 The FSM SHALL have three states:
- IDLE, FETCH, FLUSH.
- IDLE->FETCH when fifo_empty=0.
- FETCH->IDLE when fifo_empty=1 and no read is in flight.
- Any state->FLUSH on flush=1.
- FLUSH->IDLE after RD_LATENCY+1 cycles.
REQ-016 ren SHALL assert only in FETCH, only when fifo_empty=0 and (buffer occupancy + in-flight reads) < 2.
REQ-017 Each ren pulse SHALL capture exactly one rdata word into a 2-entry skid buffer RD_LATENCY cycles later.
REQ-018 m_valid SHALL be high whenever the buffer is non-empty; m_data SHALL be the oldest entry and SHALL be held stable while m_valid=1 and m_ready=0.
REQ-019 With continuous m_ready=1 and a non-empty FIFO, throughput SHALL be one word per cycle for RD_LATENCY=1.
REQ-020 A word pushed and a word popped in the same cycle SHALL leave occupancy unchanged.
REQ-021 The buffer SHALL never overflow; the ren gating in REQ-016 guarantees this.
REQ-022 On flush:
- fflush SHALL be high for exactly one cycle.
- ren SHALL be forced low.
- The buffer SHALL be cleared.
- rdata returning from reads already in flight SHALL be discarded.
- m_valid SHALL be low from the cycle after flush until FLUSH exits.
REQ-023 flush asserted again while in FLUSH SHALL restart the FLUSH cycle count.
REQ-024 rd_count SHALL increment by 1 per accepted word and wrap from 16'hFFFF to 0; flush SHALL NOT clear rd_count.

Reset
REQ-025 Asserting rst_n low SHALL immediately:
- set the state to IDLE;
- drive ren=0, fflush=0 and m_valid=0;
- set m_data=0 and rd_count=0;
- clear the buffer and the in-flight tracking.
REQ-026 Reset asserted mid-read SHALL discard all in-flight data; the first word after reset is the next word the FIFO presents.

Configuration
REQ-027 With macro RAM_FIFO_READER_BYTESWAP_EN defined, m_data SHALL be the byte-reversed rdata, so rdata 32'h11223344 gives m_data 32'h44332211; DATA_WIDTH SHALL then be a multiple of 8.
REQ-028 Without RAM_FIFO_READER_BYTESWAP_EN, m_data SHALL equal rdata unmodified.

Structure
REQ-029 A shared package SHALL hold:
- the FSM state enumeration (IDLE, FETCH, FLUSH);
- the constants SKID_DEPTH=2 and CNT_W=16.
REQ-030 The skid buffer SHALL be a sub-module named ram_fifo_reader_skid, with push, pop, data, occupancy and clear ports.

Verification
REQ-031 Reset with fifo_empty=0 SHALL give ren=0, m_valid=0 and rd_count=0 throughout reset; the first ren SHALL come no earlier than the second clock edge after release.
REQ-032 A FIFO holding 4 words (1,2,3,4) with m_ready=1 SHALL produce m_data 1,2,3,4 on 4 consecutive m_valid cycles, then rd_count=4.
REQ-033 With m_ready=0 and the FIFO non-empty, ren SHALL pulse exactly 2 times, m_valid SHALL stay 1 and m_data SHALL hold the first word.
REQ-034 flush asserted one cycle after ren SHALL give fflush for 1 cycle; the in-flight word SHALL never appear on m_data, and m_valid SHALL be 0 for RD_LATENCY+1 cycles.
REQ-035 m_ready toggling 1,0,1,0 against a FIFO of 8 words SHALL produce all 8 words in order, with none lost or duplicated.
REQ-036 rd_count preloaded near wrap (16'hFFFE) plus 3 accepted words SHALL read 16'h0001.

Source files
------------

// File: rtl/ram_fifo_reader_pkg.sv
// Shared FSM state encoding and sizing constants for the RAM FIFO reader.
package ram_fifo_reader_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = 16;
  localparam int OCC_W      = 2;
endpackage

// File: rtl/ram_fifo_reader_skid.sv
// Two-entry skid buffer: push/pop in one cycle; o_data is the oldest entry, registered.
// No internal backpressure; the caller's read credit keeps it from overflowing.
module ram_fifo_reader_skid
  import ram_fifo_reader_pkg::*;
#(
  parameter int W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [W-1:0]     i_data,
  input  logic             i_pop,
  output logic [W-1:0]     o_data,
  output logic [OCC_W-1:0] o_occupancy
);
  logic [W-1:0]     r_mem [SKID_DEPTH];
  logic             r_wr;
  logic             r_rd;
  logic [OCC_W-1:0] r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) r_mem[i] <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_occ <= '0;
    end else if (i_clear) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_occ <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= i_data;
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data      = r_mem[r_rd];
  assign o_occupancy = r_occ;
endmodule

// File: rtl/ram_fifo_reader.sv
// Drains a RAM FIFO into a valid/ready stream; RD_LATENCY+1 cycles ren-to-m_valid, ren held off by m_ready.
// Optional byte reversal of each word when RAM_FIFO_READER_BYTESWAP_EN is defined.
module ram_fifo_reader
  import ram_fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  ren,
  output logic                  fflush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_W-1:0]      rd_count
);
  state_e                r_state;
  logic [RD_LATENCY-1:0] r_pipe;
  logic [1:0]            r_fl_cnt;
  logic                  r_fflush;
  logic [CNT_W-1:0]      r_cnt;

  logic [OCC_W-1:0]      w_occ;
  logic [1:0]            w_infl;
  logic [2:0]            w_cred;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_ren;
  logic [DATA_WIDTH-1:0] w_push_dat;

  always_comb begin
    w_infl = '0;
    for (int i = 0; i < RD_LATENCY; i++) w_infl = w_infl + {1'b0, r_pipe[i]};
  end

  // A word leaving this cycle frees its slot for the read issued now.
  assign w_pop  = m_valid & m_ready;
  assign w_cred = {1'b0, w_occ} + {1'b0, w_infl} - {2'b0, w_pop};
  assign w_ren  = (r_state == ST_FETCH) && !fifo_empty && !flush && (w_cred < 3'd2);
  assign w_push = r_pipe[RD_LATENCY-1];

`ifdef RAM_FIFO_READER_BYTESWAP_EN
  always_comb begin
    w_push_dat = '0;
    for (int b = 0; b < DATA_WIDTH / 8; b++)
      w_push_dat[8*b +: 8] = rdata[DATA_WIDTH-8-8*b +: 8];
  end
`else
  always_comb w_push_dat = rdata;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_pipe   <= '0;
      r_fl_cnt <= '0;
      r_fflush <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_fflush <= flush;
      if (w_pop) r_cnt <= r_cnt + 1'b1;
      // Dropping the pipe bits discards any rdata still on its way back.
      if (flush) begin
        r_pipe <= '0;
      end else begin
        r_pipe[0] <= w_ren;
        for (int i = 1; i < RD_LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
      if (flush) begin
        r_state  <= ST_FLUSH;
        r_fl_cnt <= 2'(RD_LATENCY);
      end else begin
        case (r_state)
          ST_IDLE:  if (!fifo_empty) r_state <= ST_FETCH;
          ST_FETCH: if (fifo_empty && (w_infl == 2'd0)) r_state <= ST_IDLE;
          ST_FLUSH: begin
            if (r_fl_cnt == 2'd0) r_state <= ST_IDLE;
            else r_fl_cnt <= r_fl_cnt - 2'd1;
          end
          default:  r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ram_fifo_reader_skid #(
    .W (DATA_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (flush),
    .i_push      (w_push),
    .i_data      (w_push_dat),
    .i_pop       (w_pop),
    .o_data      (m_data),
    .o_occupancy (w_occ)
  );

  assign m_valid  = (w_occ != '0);
  assign ren      = w_ren;
  assign fflush   = r_fflush;
  assign rd_count = r_cnt;
endmodule
